hm_cpl: RTL and testbench

PCIe memory-read completer on the Xilinx TRN 64-bit interface: the responder end of the host-memory read path, answering 1-DW memory read requests from the link partner. Accepts MRd32/MRd64 TLPs hitting BAR0, reads one DWORD from a local synchronous RAM port, and returns a CplD TLP. Everything else is discarded and counted. Sits beside the host-memory TX/RX engines on the same `trn_clk` domain.

---
 rtl/hm_cpl.sv | 191 +++++++++++++++++++
 tb/tb_hm_cpl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hm_cpl.sv
// hm_cpl: PCIe 1-DW memory-read completer on the TRN 64-bit interface.
// Accepts MRd32/MRd64 (length 1, BAR0) and reads one DWORD from local RAM.
// Answers each accepted request with a CplD. All other TLPs are discarded
// and counted.
// Ports:
//   trn_clk / trn_reset_n       clock, async active-low reset
//   trn_lnk_up_n                link status (1 = down)
//   trn_r*                      RX TRN interface (trn_rdst_rdy_n driven here)
//   trn_t*                      TX TRN interface (trn_tdst_rdy_n is input)
//   completer_id                bus/dev/func placed into the CplD
//   mem_addr / mem_data         synchronous RAM port, 1-cycle read latency
//   stat_cpt_rx/_cpl/_drop      wrapping TLP counters
module hm_cpl (
  input  logic        trn_clk,
  input  logic        trn_reset_n,
  input  logic        trn_lnk_up_n,
  input  logic [63:0] trn_rd,
  input  logic        trn_rrem_n,
  input  logic        trn_rsof_n,
  input  logic        trn_reof_n,
  input  logic        trn_rsrc_rdy_n,
  input  logic        trn_rsrc_dsc_n,
  input  logic        trn_rerrfwd_n,
  input  logic [6:0]  trn_rbar_hit_n,
  output logic        trn_rdst_rdy_n,
  output logic        trn_rnp_ok_n,
  output logic [63:0] trn_td,
  output logic        trn_trem_n,
  output logic        trn_tsof_n,
  output logic        trn_teof_n,
  output logic        trn_tsrc_rdy_n,
  input  logic        trn_tdst_rdy_n,
  output logic        trn_tsrc_dsc_n,
  output logic        trn_terrfwd_n,
  output logic        trn_tstr_n,
  output logic        trn_tcfg_gnt_n,
  input  logic [15:0] completer_id,
  output logic [9:0]  mem_addr,
  input  logic [31:0] mem_data,
  output logic [31:0] stat_cpt_rx,
  output logic [31:0] stat_cpt_cpl,
  output logic [31:0] stat_cpt_drop
);

  localparam int unsigned DW_W  = 32;
  localparam int unsigned CNT_W = 32;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR2, S_DROP, S_MEM, S_WAIT, S_TX0, S_TX1
  } state_t;

  state_t            state;
  logic [2:0]        tc;
  logic [1:0]        attr;
  logic [15:0]       req_id;
  logic [7:0]        tag;
  logic              four_dw;
  logic [4:0]        lo_addr;
  logic [DW_W-1:0]   cpl_data;

  logic              rx_beat_c;
  logic              req_ok_c;
  logic [9:0]        hdr_addr_c;
  logic [DW_W-1:0]   cpl_dw0_c;
  logic [DW_W-1:0]   cpl_dw1_c;
  logic [DW_W-1:0]   cpl_dw2_c;
  logic              unused_c;

  // Tied TRN sideband outputs
  assign trn_rnp_ok_n   = 1'b0;
  assign trn_tsrc_dsc_n = 1'b1;
  assign trn_terrfwd_n  = 1'b1;
  assign trn_tstr_n     = 1'b1;
  assign trn_tcfg_gnt_n = 1'b0;

  // RX ready only while parsing/discarding: one request outstanding at a time
  assign trn_rdst_rdy_n = !((state == S_IDLE) || (state == S_HDR2) || (state == S_DROP));
  assign rx_beat_c      = !trn_rsrc_rdy_n && !trn_rdst_rdy_n;

  // Header DW0 is trn_rd[63:32]: fmt[62:61], type[60:56], length[41:32]
  assign req_ok_c = !trn_rd[62] && (trn_rd[60:56] == 5'b00000) &&
                    (trn_rd[41:32] == 10'd1) && !trn_rbar_hit_n[0] &&
                    trn_rerrfwd_n && trn_reof_n;

  // Address DW sits in the upper half for 3DW headers, lower half for 4DW
  assign hdr_addr_c = four_dw ? trn_rd[11:2] : trn_rd[43:34];

  assign cpl_dw0_c = {1'b0, 2'b10, 5'b01010, 1'b0, tc, 4'b0000, 1'b0, 1'b0,
                      attr, 2'b00, 10'd1};
  assign cpl_dw1_c = {completer_id, 3'b000, 1'b0, 12'd4};
  assign cpl_dw2_c = {req_id, tag, 1'b0, lo_addr, 2'b00};

  // Header bits not needed for a 1-DW completion
  assign unused_c = &{1'b0, trn_rd, trn_rrem_n, trn_rbar_hit_n[6:1]};

  // Completer FSM with registered TX framing and counters
  always_ff @(posedge trn_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      state          <= S_IDLE;
      tc             <= 3'd0;
      attr           <= 2'd0;
      req_id         <= 16'd0;
      tag            <= 8'd0;
      four_dw        <= 1'b0;
      lo_addr        <= 5'd0;
      cpl_data       <= '0;
      mem_addr       <= 10'd0;
      trn_td         <= 64'd0;
      trn_tsof_n     <= 1'b1;
      trn_teof_n     <= 1'b1;
      trn_trem_n     <= 1'b1;
      trn_tsrc_rdy_n <= 1'b1;
      stat_cpt_rx    <= '0;
      stat_cpt_cpl   <= '0;
      stat_cpt_drop  <= '0;
    end else if (trn_lnk_up_n) begin
      // Link loss abandons any request or completion in flight
      state          <= S_IDLE;
      trn_tsof_n     <= 1'b1;
      trn_teof_n     <= 1'b1;
      trn_trem_n     <= 1'b1;
      trn_tsrc_rdy_n <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (rx_beat_c && !trn_rsof_n) begin
            stat_cpt_rx <= stat_cpt_rx + CNT_W'(1);
            if (req_ok_c) begin
              tc      <= trn_rd[54:52];
              attr    <= trn_rd[45:44];
              four_dw <= trn_rd[61];
              req_id  <= trn_rd[31:16];
              tag     <= trn_rd[15:8];
              state   <= S_HDR2;
            end else begin
              stat_cpt_drop <= stat_cpt_drop + CNT_W'(1);
              if (trn_reof_n) state <= S_DROP;
            end
          end
        end
        S_HDR2: begin
          if (!trn_rsrc_dsc_n) begin
            stat_cpt_drop <= stat_cpt_drop + CNT_W'(1);
            state         <= S_IDLE;
          end else if (rx_beat_c) begin
            mem_addr <= hdr_addr_c;
            lo_addr  <= hdr_addr_c[4:0];
            if (!trn_reof_n) begin
              state <= S_MEM;
            end else begin
              stat_cpt_drop <= stat_cpt_drop + CNT_W'(1);
              state         <= S_DROP;
            end
          end
        end
        S_DROP: begin
          // Drop already counted on entry; a discontinue just ends the TLP
          if (!trn_rsrc_dsc_n || (rx_beat_c && !trn_reof_n)) state <= S_IDLE;
        end
        S_MEM: state <= S_WAIT;
        S_WAIT: begin
          cpl_data       <= mem_data;
          trn_td         <= {cpl_dw0_c, cpl_dw1_c};
          trn_tsof_n     <= 1'b0;
          trn_tsrc_rdy_n <= 1'b0;
          state          <= S_TX0;
        end
        S_TX0: begin
          if (!trn_tdst_rdy_n) begin
            trn_td     <= {cpl_dw2_c, cpl_data};
            trn_tsof_n <= 1'b1;
            trn_teof_n <= 1'b0;
            trn_trem_n <= 1'b0;
            state      <= S_TX1;
          end
        end
        S_TX1: begin
          if (!trn_tdst_rdy_n) begin
            stat_cpt_cpl   <= stat_cpt_cpl + CNT_W'(1);
            trn_tsrc_rdy_n <= 1'b1;
            trn_teof_n     <= 1'b1;
            trn_trem_n     <= 1'b1;
            state          <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hm_cpl.sv
// tb_hm_cpl: directed self-checking bench for hm_cpl.
module tb_hm_cpl;

  logic        trn_clk = 1'b0;
  logic        trn_reset_n;
  logic        trn_lnk_up_n;
  logic [63:0] trn_rd;
  logic        trn_rrem_n;
  logic        trn_rsof_n;
  logic        trn_reof_n;
  logic        trn_rsrc_rdy_n;
  logic        trn_rsrc_dsc_n;
  logic        trn_rerrfwd_n;
  logic [6:0]  trn_rbar_hit_n;
  logic        trn_rdst_rdy_n;
  logic        trn_rnp_ok_n;
  logic [63:0] trn_td;
  logic        trn_trem_n;
  logic        trn_tsof_n;
  logic        trn_teof_n;
  logic        trn_tsrc_rdy_n;
  logic        trn_tdst_rdy_n;
  logic        trn_tsrc_dsc_n;
  logic        trn_terrfwd_n;
  logic        trn_tstr_n;
  logic        trn_tcfg_gnt_n;
  logic [15:0] completer_id;
  logic [9:0]  mem_addr;
  logic [31:0] mem_data;
  logic [31:0] stat_cpt_rx;
  logic [31:0] stat_cpt_cpl;
  logic [31:0] stat_cpt_drop;

  logic [31:0] ram [0:1023];
  int n_checks = 0;
  int n_errors = 0;

  localparam logic [63:0] B0     = 64'h4A000001_02000004;
  localparam logic [63:0] B1_32  = 64'h01001A44_DEADBEEF;
  localparam logic [63:0] B1_64  = 64'h01001A7C_CAFEF00D;
  localparam logic [63:0] HDR32  = 64'h00000001_01001A0F;
  localparam logic [63:0] HDR64  = 64'h20000001_01001A0F;
  localparam logic [63:0] ADDR32 = 64'h00000A44_00000000;
  localparam logic [63:0] ADDR64 = 64'h00000001_00000FFC;

  hm_cpl dut (
    .trn_clk        (trn_clk),
    .trn_reset_n    (trn_reset_n),
    .trn_lnk_up_n   (trn_lnk_up_n),
    .trn_rd         (trn_rd),
    .trn_rrem_n     (trn_rrem_n),
    .trn_rsof_n     (trn_rsof_n),
    .trn_reof_n     (trn_reof_n),
    .trn_rsrc_rdy_n (trn_rsrc_rdy_n),
    .trn_rsrc_dsc_n (trn_rsrc_dsc_n),
    .trn_rerrfwd_n  (trn_rerrfwd_n),
    .trn_rbar_hit_n (trn_rbar_hit_n),
    .trn_rdst_rdy_n (trn_rdst_rdy_n),
    .trn_rnp_ok_n   (trn_rnp_ok_n),
    .trn_td         (trn_td),
    .trn_trem_n     (trn_trem_n),
    .trn_tsof_n     (trn_tsof_n),
    .trn_teof_n     (trn_teof_n),
    .trn_tsrc_rdy_n (trn_tsrc_rdy_n),
    .trn_tdst_rdy_n (trn_tdst_rdy_n),
    .trn_tsrc_dsc_n (trn_tsrc_dsc_n),
    .trn_terrfwd_n  (trn_terrfwd_n),
    .trn_tstr_n     (trn_tstr_n),
    .trn_tcfg_gnt_n (trn_tcfg_gnt_n),
    .completer_id   (completer_id),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .stat_cpt_rx    (stat_cpt_rx),
    .stat_cpt_cpl   (stat_cpt_cpl),
    .stat_cpt_drop  (stat_cpt_drop)
  );

  always #5 trn_clk = ~trn_clk;

  // Synchronous RAM model, one-cycle read latency
  always @(posedge trn_clk) mem_data <= ram[mem_addr];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One RX beat, presented after negedge, accepted at the next posedge
  task automatic beat(input logic [63:0] d, input logic sof_n, input logic eof_n,
                      input logic rem_n, input logic dsc_n);
    @(negedge trn_clk);
    trn_rd = d; trn_rsof_n = sof_n; trn_reof_n = eof_n;
    trn_rrem_n = rem_n; trn_rsrc_dsc_n = dsc_n; trn_rsrc_rdy_n = 1'b0;
    @(posedge trn_clk); #1;
    trn_rsrc_rdy_n = 1'b1; trn_rsof_n = 1'b1; trn_reof_n = 1'b1; trn_rsrc_dsc_n = 1'b1;
  endtask

  // Follows a completion from the cycle after the address-beat EOF
  task automatic run_cpl(input string nm, input logic [63:0] b1, input int w0,
                         input int w1, input logic [31:0] exp_cpl);
    @(posedge trn_clk); #1;
    chk({nm, "_tx_early"}, 64'(trn_tsrc_rdy_n), 64'd1);
    @(posedge trn_clk); #1;
    chk({nm, "_tx0_frm"}, 64'({trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n}), 64'b001);
    chk({nm, "_tx0_td"}, trn_td, B0);
    if (w0 > 0) trn_tdst_rdy_n = 1'b1;
    for (int i = 1; i < w0; i++) begin
      @(posedge trn_clk); #1;
      chk({nm, "_tx0_hold"}, {trn_td[63:2], trn_tsof_n, trn_rdst_rdy_n}, {B0[63:2], 2'b01});
    end
    trn_tdst_rdy_n = 1'b0;
    @(posedge trn_clk); #1;
    chk({nm, "_tx1_frm"},
        64'({trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n, trn_trem_n}), 64'b0100);
    chk({nm, "_tx1_td"}, trn_td, b1);
    if (w1 > 0) trn_tdst_rdy_n = 1'b1;
    for (int i = 1; i < w1; i++) begin
      @(posedge trn_clk); #1;
      chk({nm, "_tx1_hold"}, {trn_td[63:2], trn_teof_n, trn_rdst_rdy_n}, {b1[63:2], 2'b01});
    end
    trn_tdst_rdy_n = 1'b0;
    @(posedge trn_clk); #1;
    chk({nm, "_done"}, 64'({trn_tsrc_rdy_n, trn_rdst_rdy_n}), 64'b10);
    chk({nm, "_cpl_cnt"}, 64'(stat_cpt_cpl), 64'(exp_cpl));
  endtask

  task automatic idle_quiet(input string nm);
    repeat (3) @(posedge trn_clk);
    #1;
    chk({nm, "_quiet"}, 64'({trn_tsrc_rdy_n, trn_rdst_rdy_n}), 64'b10);
  endtask

  initial begin
    ram[10'h291] = 32'hDEADBEEF;
    ram[10'h3FF] = 32'hCAFEF00D;
    trn_reset_n = 1'b0; trn_lnk_up_n = 1'b0; trn_rd = '0; trn_rrem_n = 1'b1;
    trn_rsof_n = 1'b1; trn_reof_n = 1'b1; trn_rsrc_rdy_n = 1'b1; trn_rsrc_dsc_n = 1'b1;
    trn_rerrfwd_n = 1'b1; trn_rbar_hit_n = 7'h7E; trn_tdst_rdy_n = 1'b0;
    completer_id = 16'h0200;

    // Reset values
    repeat (3) @(posedge trn_clk);
    #1;
    chk("rst_tframe", 64'({trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n, trn_trem_n}), 64'hF);
    chk("rst_td", trn_td, 64'd0);
    chk("rst_maddr", 64'(mem_addr), 64'd0);
    chk("rst_cnts", {stat_cpt_rx, stat_cpt_cpl | stat_cpt_drop}, 64'd0);
    chk("rst_ties", 64'({trn_rnp_ok_n, trn_tsrc_dsc_n, trn_terrfwd_n, trn_tstr_n, trn_tcfg_gnt_n}),
        64'b01110);
    @(negedge trn_clk); trn_reset_n = 1'b1;
    @(posedge trn_clk); #1;
    chk("rst_rdy", 64'(trn_rdst_rdy_n), 64'd0);

    // MRd32 with no backpressure
    beat(HDR32, 1'b0, 1'b1, 1'b0, 1'b1);
    beat(ADDR32, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("m32_maddr", 64'(mem_addr), 64'h291);
    run_cpl("m32", B1_32, 0, 0, 32'd1);
    chk("m32_rx", 64'(stat_cpt_rx), 64'd1);

    // MRd64, top DWORD of RAM
    beat(HDR64, 1'b0, 1'b1, 1'b0, 1'b1);
    beat(ADDR64, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("m64_maddr", 64'(mem_addr), 64'h3FF);
    run_cpl("m64", B1_64, 0, 0, 32'd2);

    // TX backpressure: 5 cycles on TX0, 3 on TX1
    beat(HDR32, 1'b0, 1'b1, 1'b0, 1'b1);
    beat(ADDR32, 1'b1, 1'b0, 1'b1, 1'b1);
    run_cpl("bp", B1_32, 5, 3, 32'd3);
    idle_quiet("bp");
    chk("bp_cpl_once", 64'(stat_cpt_cpl), 64'd3);

    // MWr32 with 4 DW payload
    beat(64'h40000004_01001A0F, 1'b0, 1'b1, 1'b0, 1'b1);
    beat(64'h00000A44_11111111, 1'b1, 1'b1, 1'b0, 1'b1);
    beat(64'h22222222_33333333, 1'b1, 1'b1, 1'b0, 1'b1);
    beat(64'h44444444_00000000, 1'b1, 1'b0, 1'b1, 1'b1);
    idle_quiet("mwr");
    chk("mwr_drop", 64'(stat_cpt_drop), 64'd1);

    // MRd length 2
    beat(64'h00000002_01001A0F, 1'b0, 1'b1, 1'b0, 1'b1);
    beat(ADDR32, 1'b1, 1'b0, 1'b1, 1'b1);
    idle_quiet("len2");
    chk("len2_drop", 64'(stat_cpt_drop), 64'd2);

    // MRd hitting BAR1
    trn_rbar_hit_n = 7'h7D;
    beat(HDR32, 1'b0, 1'b1, 1'b0, 1'b1);
    beat(ADDR32, 1'b1, 1'b0, 1'b1, 1'b1);
    trn_rbar_hit_n = 7'h7E;
    idle_quiet("bar1");
    chk("bar1_drop", 64'(stat_cpt_drop), 64'd3);

    // MRd discontinued on the address beat
    beat(HDR32, 1'b0, 1'b1, 1'b0, 1'b1);
    beat(ADDR32, 1'b1, 1'b0, 1'b1, 1'b0);
    idle_quiet("dsc");
    chk("dsc_drop", 64'(stat_cpt_drop), 64'd4);
    chk("drops_rx", 64'(stat_cpt_rx), 64'd7);
    chk("drops_cpl", 64'(stat_cpt_cpl), 64'd3);

    // Link down while waiting on RAM: completion lost
    beat(HDR32, 1'b0, 1'b1, 1'b0, 1'b1);
    beat(ADDR32, 1'b1, 1'b0, 1'b1, 1'b1);
    @(posedge trn_clk); #1;
    trn_lnk_up_n = 1'b1;
    @(posedge trn_clk); #1;
    trn_lnk_up_n = 1'b0;
    chk("lnk_idle", 64'({trn_tsrc_rdy_n, trn_rdst_rdy_n}), 64'b10);
    idle_quiet("lnk");
    chk("lnk_cpl", 64'(stat_cpt_cpl), 64'd3);
    beat(HDR32, 1'b0, 1'b1, 1'b0, 1'b1);
    beat(ADDR32, 1'b1, 1'b0, 1'b1, 1'b1);
    run_cpl("relnk", B1_32, 0, 0, 32'd4);
    chk("relnk_rx", 64'(stat_cpt_rx), 64'd9);

    // Async reset in the middle of TX1
    beat(HDR32, 1'b0, 1'b1, 1'b0, 1'b1);
    beat(ADDR32, 1'b1, 1'b0, 1'b1, 1'b1);
    repeat (3) @(posedge trn_clk);
    #1;
    chk("ar_in_tx1", 64'({trn_tsrc_rdy_n, trn_teof_n}), 64'b00);
    #2;
    trn_reset_n = 1'b0;
    #1;
    chk("ar_tframe", 64'({trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n, trn_trem_n}), 64'hF);
    chk("ar_td", trn_td, 64'd0);
    chk("ar_maddr", 64'(mem_addr), 64'd0);
    chk("ar_cnts", {stat_cpt_rx, stat_cpt_cpl | stat_cpt_drop}, 64'd0);
    @(negedge trn_clk); trn_reset_n = 1'b1;
    @(posedge trn_clk); #1;
    chk("ar_rdy", 64'(trn_rdst_rdy_n), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
